// File: rtl/amm_rd_master_pkg.sv
// amm_rd_master shared types and width helpers.
// Imported by the read master and its response FIFO.
package amm_rd_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_e;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DEPTH_DEF  = 8;

  localparam int unsigned LEN_W_DEF  = ADDR_W_DEF + 1;
  localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF) + 1;

  function automatic int unsigned ptr_w(
    input int unsigned depth
  );
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counters must reach depth itself.
  function automatic int unsigned cnt_w(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/amm_rd_master_fifo.sv
// amm_rd_fifo: synchronous show-ahead response buffer.
// Head word is visible combinationally; writes appear next cycle.
module amm_rd_fifo
  import amm_rd_master_pkg::*;
#(
  parameter int unsigned W     = DATA_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] used_o
);

  localparam int unsigned PW = ptr_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] used_q, used_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (used_q == '0);
  assign full_o  = (used_q == CW'(DEPTH));
  assign used_o  = used_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Gate the head so an empty buffer shows zero.
  assign data_o = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    used_d = used_q;
    if (do_push) begin
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    used_d = used_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      used_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      used_q <= used_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/amm_rd_master.sv
// amm_rd_master: Avalon-MM block read master.
// Streams a contiguous word range out through a credit-limited FIFO.
module amm_rd_master
  import amm_rd_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = DEPTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  run_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
  output logic                  amm_rd_read_o,
  input  logic                  amm_rd_waitrequest_i,
  input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
  input  logic                  amm_rd_readdatavalid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i
);

  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned CW = cnt_w(FIFO_DEPTH);
  localparam int unsigned SW = CW + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         left_q, left_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         out_q, out_d;
  logic                  held_q, held_d;

  logic                  rd;
  logic                  accept;
  logic                  rsp;
  logic                  pop;
  logic                  credit;
  logic                  is_last;
  logic [SW-1:0]         inflight;
  logic [CW-1:0]         used;
  logic                  empty;
  logic                  full;

  amm_rd_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .push_i  (rsp),
    .wdata_i (amm_rd_readdata_i),
    .pop_i   (pop),
    .data_o  (data_o),
    .empty_o (empty),
    .full_o  (full),
    .used_o  (used)
  );

  // Every raised read reserves a FIFO slot for its answer.
  assign inflight = {1'b0, out_q} + {1'b0, used};
  assign credit   = !full && (inflight < SW'(FIFO_DEPTH));

  assign rd     = (state_q == REQ) && (held_q || credit);
  assign accept = rd && !amm_rd_waitrequest_i;
  assign rsp    = amm_rd_readdatavalid_i && (out_q != '0);

  assign valid_o = !empty;
  assign pop     = valid_o && ready_i;
  assign is_last = (idx_q == len_q - 1'b1);
  assign last_o  = valid_o && is_last;

  assign busy_o           = (state_q != IDLE);
  assign amm_rd_read_o    = rd;
  assign amm_rd_address_o = addr_q;

  always_comb begin
    out_d  = out_q + CW'(accept) - CW'(rsp);
    held_d = rd && amm_rd_waitrequest_i;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    left_d  = left_q;
    idx_d   = idx_q;
    if (accept) begin
      addr_d = addr_q + 1'b1;
      left_d = left_q - 1'b1;
    end
    if (pop) begin
      idx_d = idx_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (run_i && (length_i != '0)) begin
          state_d = REQ;
          addr_d  = base_addr_i;
          len_d   = length_i;
          left_d  = length_i;
          idx_d   = '0;
        end
      end
      REQ: begin
        if (accept && (left_q == LW'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && is_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      left_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      left_q  <= left_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      held_q  <= held_d;
    end
  end

endmodule

// File: tb/tb_amm_rd_master.sv
// tb_amm_rd_master: directed bench with a memory agent and
// a transaction-level model checked every cycle.
module tb_amm_rd_master;

  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          run = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy_o;
  logic [AW-1:0] addr_o;
  logic          read_o;
  logic          wreq = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rdv = 1'b0;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic          ready = 1'b1;

  always #5 clk = ~clk;

  amm_rd_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i                  (clk),
    .srst_i                 (srst),
    .run_i                  (run),
    .base_addr_i            (base),
    .length_i               (len),
    .busy_o                 (busy_o),
    .amm_rd_address_o       (addr_o),
    .amm_rd_read_o          (read_o),
    .amm_rd_waitrequest_i   (wreq),
    .amm_rd_readdata_i      (rdata),
    .amm_rd_readdatavalid_i (rdv),
    .data_o                 (data_o),
    .valid_o                (valid_o),
    .last_o                 (last_o),
    .ready_i                (ready)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
  } word_t;

  typedef struct {
    int            due;
    logic [AW-1:0] a;
  } rsp_t;

  word_t exp_q[$];
  rsp_t  pend_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int lat_min = 1;
  int lat_max = 1;
  int wait_pct = 0;
  int ready_mode = 0;
  bit spur_req = 0;

  bit            m_busy = 0;
  logic [AW-1:0] m_addr = '0;
  int            m_issued = 0;
  int            m_len = 0;
  int            m_out = 0;
  int            m_buf = 0;
  int            last_due = 0;
  bit            p_stall = 0;
  bit            p_hold = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_data = '0;
  bit            p_busy = 0;

  int            acc_cnt = 0;
  int            hs_cnt = 0;
  int            last_cnt = 0;
  int            last_hs_cyc = -1;
  int            busy_fall = -1;
  logic [AW-1:0] acc_a[$];
  int            acc_c[$];
  logic [DW-1:0] hs_d[$];
  bit            hs_l[$];

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return 64'h0123_4567_0000_0000 | {54'd0, a};
  endfunction

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  // Memory agent, model update and per-cycle compare.
  always @(negedge clk) begin
    bit            acc;
    bit            rsp;
    bit            hs;
    bit            was_busy;
    int            lat;
    int            due;
    logic [AW-1:0] a;
    cyc++;

    chk("busy", 64'(busy_o), 64'(m_busy));
    chk("valid", 64'(valid_o), 64'(m_buf > 0));
    if (p_stall) begin
      chk("rd_hold", 64'(read_o), 64'd1);
      chk("addr_hold", 64'(addr_o), 64'(p_addr));
    end
    if (p_hold) chk("data_hold", data_o, p_data);
    if (m_buf > 0 && exp_q.size() > 0) begin
      chk("data", data_o, exp_q[0].d);
      chk("last", 64'(last_o), 64'(exp_q[0].l));
    end
    if (read_o) begin
      chk("rd_credit", 64'((m_out + m_buf < DEPTH) || p_stall), 64'd1);
      chk("rd_in_block", 64'(m_busy && (m_issued < m_len)), 64'd1);
    end

    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rdv   = 1'b1;
      rdata = memfn(pend_q[0].a);
      void'(pend_q.pop_front());
    end else if (spur_req) begin
      rdv      = 1'b1;
      rdata    = 64'hDEAD_BEEF_DEAD_BEEF;
      spur_req = 0;
    end else begin
      rdv   = 1'b0;
      rdata = '0;
    end
    wreq = (int'($urandom_range(0, 99)) < wait_pct);
    if (ready_mode == 0) ready = 1'b1;
    else if (ready_mode == 1) ready = 1'b0;
    else ready = (int'($urandom_range(0, 99)) < 70);

    acc = read_o && !wreq;
    if (acc) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{due, addr_o});
    end

    if (srst) begin
      m_busy  = 0;
      m_out   = 0;
      m_buf   = 0;
      p_stall = 0;
      p_hold  = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      rsp = rdv && (m_out > 0);
      hs  = valid_o && ready;
      if (acc) begin
        chk("rd_addr", 64'(addr_o), 64'(m_addr));
        acc_cnt++;
        acc_a.push_back(addr_o);
        acc_c.push_back(cyc);
        m_addr = m_addr + 1'b1;
        m_issued++;
        m_out++;
      end
      if (rsp) begin
        m_out--;
        m_buf++;
      end
      if (hs) begin
        hs_cnt++;
        hs_d.push_back(data_o);
        hs_l.push_back(last_o);
        if (last_o) last_cnt++;
        if (exp_q.size() > 0) begin
          if (exp_q[0].l) begin
            m_busy = 0;
            last_hs_cyc = cyc;
          end
          void'(exp_q.pop_front());
        end
        if (m_buf > 0) m_buf--;
      end
      if (run && !was_busy && (len != '0)) begin
        m_busy   = 1;
        m_addr   = base;
        m_issued = 0;
        m_len    = int'(len);
        for (int i = 0; i < int'(len); i++) begin
          a = AW'(int'(base) + i);
          exp_q.push_back('{memfn(a), (i == int'(len) - 1)});
        end
      end
      p_stall = read_o && wreq;
      p_addr  = addr_o;
      p_hold  = valid_o && !ready;
      p_data  = data_o;
    end
    if (p_busy && !busy_o) busy_fall = cyc;
    p_busy = busy_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rec();
    acc_cnt = 0;
    hs_cnt = 0;
    last_cnt = 0;
    last_hs_cyc = -1;
    busy_fall = -1;
    acc_a.delete();
    acc_c.delete();
    hs_d.delete();
    hs_l.delete();
  endtask

  task automatic start(input logic [AW-1:0] b, input logic [AW:0] l);
    run  = 1'b1;
    base = b;
    len  = l;
    tick();
    run  = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    tick();
    while ((m_busy || pend_q.size() > 0) && n < max) begin
      tick();
      n++;
    end
    total++;
    if (n >= max) begin
      bad++;
      $display("FAIL idle_timeout: waited %0d cycles, limit %0d", n, max);
    end
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int hs_before;
    repeat (3) tick();
    srst = 1'b0;
    tick();

    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_read", 64'(read_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_last", 64'(last_o), 64'd0);
    chk("rst_data", data_o, 64'd0);

    // Basic fixed speed
    clear_rec();
    lat_min = 1; lat_max = 1; wait_pct = 0; ready_mode = 0;
    start(10'h010, 11'd4);
    wait_idle(200);
    chk("t1_acc", 64'(acc_cnt), 64'd4);
    chk("t1_a0", 64'(acc_a[0]), 64'h010);
    chk("t1_a3", 64'(acc_a[3]), 64'h013);
    chk("t1_b2b", 64'(acc_c[3] - acc_c[0]), 64'd3);
    chk("t1_hs", 64'(hs_cnt), 64'd4);
    chk("t1_d0", hs_d[0], 64'h0123_4567_0000_0010);
    chk("t1_d3", hs_d[3], 64'h0123_4567_0000_0013);
    chk("t1_lastpat", 64'({hs_l[3], hs_l[2], hs_l[1], hs_l[0]}), 64'b1000);
    chk("t1_busyfall", 64'(busy_fall - last_hs_cyc), 64'd1);

    // Random latency and stalls across the wrap
    clear_rec();
    lat_min = 1; lat_max = 64; wait_pct = 40; ready_mode = 2;
    start(10'h3F0, 11'd32);
    wait_idle(6000);
    chk("t2_acc", 64'(acc_cnt), 64'd32);
    chk("t2_hs", 64'(hs_cnt), 64'd32);
    chk("t2_a15", 64'(acc_a[15]), 64'h3FF);
    chk("t2_a16", 64'(acc_a[16]), 64'h000);
    chk("t2_d16", hs_d[16], 64'h0123_4567_0000_0000);
    chk("t2_d31", hs_d[31], 64'h0123_4567_0000_000F);
    chk("t2_lastcnt", 64'(last_cnt), 64'd1);

    // Downstream stall
    clear_rec();
    lat_min = 1; lat_max = 4; wait_pct = 0; ready_mode = 1;
    start(10'h080, 11'd20);
    repeat (100) tick();
    chk("t3_acc_cap", 64'(acc_cnt), 64'd8);
    chk("t3_read_low", 64'(read_o), 64'd0);
    chk("t3_no_hs", 64'(hs_cnt), 64'd0);
    ready_mode = 0;
    wait_idle(500);
    chk("t3_acc", 64'(acc_cnt), 64'd20);
    chk("t3_hs", 64'(hs_cnt), 64'd20);
    chk("t3_lastcnt", 64'(last_cnt), 64'd1);

    // Zero length and run while busy
    clear_rec();
    lat_min = 2; lat_max = 2; wait_pct = 0; ready_mode = 0;
    start(10'h055, 11'd0);
    repeat (10) tick();
    chk("t4_len0_busy", 64'(busy_o), 64'd0);
    chk("t4_len0_acc", 64'(acc_cnt), 64'd0);
    start(10'h100, 11'd6);
    tick();
    start(10'h200, 11'd3);
    wait_idle(300);
    chk("t4_acc", 64'(acc_cnt), 64'd6);
    chk("t4_a5", 64'(acc_a[5]), 64'h105);
    chk("t4_hs", 64'(hs_cnt), 64'd6);
    chk("t4_addr_end", 64'(addr_o), 64'h106);

    // Full range
    clear_rec();
    lat_min = 1; lat_max = 1; wait_pct = 0; ready_mode = 0;
    start(10'h000, 11'd1024);
    wait_idle(5000);
    chk("t5_acc", 64'(acc_cnt), 64'd1024);
    chk("t5_hs", 64'(hs_cnt), 64'd1024);
    chk("t5_lastcnt", 64'(last_cnt), 64'd1);
    chk("t5_last1023", 64'(hs_l[1023]), 64'd1);
    chk("t5_last1022", 64'(hs_l[1022]), 64'd0);

    // Reset mid-operation with late responses
    clear_rec();
    lat_min = 10; lat_max = 30; wait_pct = 20; ready_mode = 0;
    start(10'h020, 11'd16);
    n = 0;
    while (hs_cnt < 5 && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_reach5", 64'(hs_cnt >= 5), 64'd1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_read", 64'(read_o), 64'd0);
    chk("t6_addr", 64'(addr_o), 64'd0);
    chk("t6_valid", 64'(valid_o), 64'd0);
    chk("t6_last", 64'(last_o), 64'd0);
    chk("t6_data", data_o, 64'd0);
    hs_before = hs_cnt;
    spur_req = 1;
    repeat (150) tick();
    chk("t6_pend_drained", 64'(pend_q.size()), 64'd0);
    chk("t6_no_valid", 64'(valid_o), 64'd0);
    chk("t6_no_hs", 64'(hs_cnt - hs_before), 64'd0);
    clear_rec();
    lat_min = 1; lat_max = 8; wait_pct = 20;
    start(10'h300, 11'd16);
    wait_idle(1000);
    chk("t6_acc", 64'(acc_cnt), 64'd16);
    chk("t6_hs", 64'(hs_cnt), 64'd16);
    chk("t6_d0", hs_d[0], 64'h0123_4567_0000_0300);
    chk("t6_lastcnt", 64'(last_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
